// File: rtl/pipeline_stall_controller.sv
// Hazard and flow controller beside decode: load-use bubble, memory freeze, jump flush, branch hold.
// Enables are combinational from state, internal registers and inputs; stall_cnt counts pc_en=0 cycles.
module pipeline_stall_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic        mem_en_ex,
  input  logic        mem_ready,
  input  logic        cond_valid,
  input  logic        cond_taken,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        ex_en,
  output logic        idex_bubble,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, BR_WAIT} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       ld_ex;
  logic [4:0] ld_rd;
  logic       mem_done;

  logic is_jmp;
  logic is_cj;
  logic is_ld;
  logic load_use;
  logic mem_stall;

  assign is_jmp    = (ins[31:26] == 6'b011000);
  assign is_cj     = (ins[31:28] == 4'b0111);
  assign is_ld     = (ins[31:26] == 6'b010100);
  assign load_use  = ld_ex && ((ld_rd == ins[20:16]) || (ld_rd == ins[15:11]));
  // mem_done stops a still-asserted mem_en_ex from re-stalling right after MEM_WAIT exits
  assign mem_stall = mem_en_ex && !mem_ready && !mem_done;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ex_en       = 1'b1;
    pc_sel      = 2'b00;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_nxt   = state;
    if (reset) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      ex_en   = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            ex_en     = 1'b0;
            state_nxt = MEM_WAIT;
          end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end else if (is_cj) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            state_nxt  = BR_WAIT;
          end else if (is_jmp) begin
            pc_sel     = 2'b01;
            ifid_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          ex_en   = 1'b0;
          if (mem_ready) state_nxt = RUN;
        end
        BR_WAIT: begin
          // IF/ID keeps the NOP loaded on detect; only PC and execute move on resolve
          ifid_en = 1'b0;
          if (cond_valid) begin
            pc_sel    = cond_taken ? 2'b10 : 2'b00;
            state_nxt = RUN;
          end else begin
            pc_en = 1'b0;
            ex_en = 1'b0;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      ld_ex     <= 1'b0;
      ld_rd     <= 5'd0;
      mem_done  <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if ((state == MEM_WAIT) && mem_ready) begin
        mem_done <= 1'b1;
      end else if (ex_en) begin
        mem_done <= 1'b0;
      end
      if (ex_en) begin
        ld_ex <= is_ld && !idex_bubble && !ifid_flush;
        ld_rd <= ins[25:21];
      end
      if (!pc_en && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized and directed bench for pipeline_stall_controller against an action-table reference model.
module tb_pipeline_stall_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ins = 32'd0;
  logic        mem_en_ex = 1'b0;
  logic        mem_ready = 1'b0;
  logic        cond_valid = 1'b0;
  logic        cond_taken = 1'b0;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        ifid_en;
  logic        ifid_flush;
  logic        ex_en;
  logic        idex_bubble;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller dut (
    .clk(clk), .reset(reset), .ins(ins), .mem_en_ex(mem_en_ex), .mem_ready(mem_ready),
    .cond_valid(cond_valid), .cond_taken(cond_taken), .pc_en(pc_en), .pc_sel(pc_sel),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .ex_en(ex_en), .idex_bubble(idex_bubble),
    .stall_cnt(stall_cnt)
  );

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] JMP = 32'h6000_0000;
  localparam logic [31:0] CJ  = 32'h7000_0000;

  // Pipeline actions the model chooses between each cycle
  localparam int A_FREEZE = 0, A_BUBBLE = 1, A_BRDET = 2, A_JUMP = 3;
  localparam int A_NORMAL = 4, A_RES_T = 5, A_RES_NT = 6;

  // Model: 0 running, 1 waiting for memory, 2 waiting for branch outcome
  int         mode = 0;
  bit         m_ld = 1'b0;
  logic [4:0] m_rd = 5'd0;
  bit         m_served = 1'b0;
  int         m_stalls = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {pc_en, ifid_en, ex_en, pc_sel[1:0], ifid_flush, idex_bubble}
  function automatic logic [6:0] effect(input int a);
    case (a)
      A_FREEZE: return 7'b000_00_0_0;
      A_BUBBLE: return 7'b001_00_0_1;
      A_BRDET:  return 7'b011_00_1_0;
      A_JUMP:   return 7'b111_01_1_0;
      A_RES_T:  return 7'b101_10_0_0;
      A_RES_NT: return 7'b101_00_0_0;
      default:  return 7'b111_00_0_0;
    endcase
  endfunction

  function automatic int pick_action(input logic [31:0] i, input bit me, input bit mr,
                                     input bit cv, input bit ct);
    if (mode == 1) return A_FREEZE;
    if (mode == 2) return cv ? (ct ? A_RES_T : A_RES_NT) : A_FREEZE;
    if (me && !mr && !m_served) return A_FREEZE;
    if (m_ld && (m_rd == i[20:16] || m_rd == i[15:11])) return A_BUBBLE;
    if (i[31:28] == 4'b0111) return A_BRDET;
    if (i[31:26] == 6'b011000) return A_JUMP;
    return A_NORMAL;
  endfunction

  task automatic cyc(input logic [31:0] i, input bit me, input bit mr, input bit cv,
                     input bit ct, input bit chk);
    int         a;
    logic [6:0] e;
    @(negedge clk);
    ins = i; mem_en_ex = me; mem_ready = mr; cond_valid = cv; cond_taken = ct;
    #1;
    a = pick_action(i, me, mr, cv, ct);
    e = effect(a);
    if (chk) begin
      check("pc_en", 32'(pc_en), 32'(e[6]));
      check("ifid_en", 32'(ifid_en), 32'(e[5]));
      check("ex_en", 32'(ex_en), 32'(e[4]));
      check("pc_sel", 32'(pc_sel), 32'(e[3:2]));
      check("ifid_flush", 32'(ifid_flush), 32'(e[1]));
      check("idex_bubble", 32'(idex_bubble), 32'(e[0]));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    end
    if (!e[6] && m_stalls < 65535) m_stalls++;
    if (e[4]) begin
      m_ld = (i[31:26] == 6'b010100) && (a == A_NORMAL || a == A_RES_T || a == A_RES_NT);
      m_rd = i[25:21];
      m_served = 1'b0;
    end
    if (mode == 1 && mr) begin
      mode = 0;
      m_served = 1'b1;
    end else if (mode == 0 && a == A_FREEZE) begin
      mode = 1;
    end else if (a == A_BRDET) begin
      mode = 2;
    end else if (a == A_RES_T || a == A_RES_NT) begin
      mode = 0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    ins = NOP; mem_en_ex = 1'b0; mem_ready = 1'b0; cond_valid = 1'b0; cond_taken = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_ifid_en", 32'(ifid_en), 32'd0);
    check("rst_ex_en", 32'(ex_en), 32'd0);
    check("rst_pc_sel", 32'(pc_sel), 32'd0);
    check("rst_flush", 32'(ifid_flush), 32'd0);
    check("rst_bubble", 32'(idex_bubble), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    #1 reset = 1'b0;
    mode = 0; m_ld = 1'b0; m_rd = 5'd0; m_served = 1'b0; m_stalls = 0;
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [31:0] w;
    w = $urandom;
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    w[15:11] = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0, 1:    w[31:26] = 6'b010100;
      2:       w[31:26] = 6'b011000;
      3:       w[31:28] = 4'b0111;
      4:       w[31:26] = 6'b010101;
      default: w[31:26] = 6'b000000;
    endcase
    return w;
  endfunction

  initial begin
    pulse_reset();

    // Load-use: LD r5 then a consumer of r5
    cyc(32'h50A0_0000, 0, 0, 0, 0, 1);
    cyc(32'h0025_0000, 0, 0, 0, 0, 1);
    check("lu_pc_en", 32'(pc_en), 32'd0);
    check("lu_bubble", 32'(idex_bubble), 32'd1);
    cyc(32'h0025_0000, 0, 0, 0, 0, 1);
    check("lu_no_stall", 32'(pc_en), 32'd1);
    check("lu_cnt", 32'(stall_cnt), 32'd1);

    // Memory stall: ready low 3 cycles, then high, mem_en_ex held
    pulse_reset();
    repeat (3) cyc(NOP, 1, 0, 0, 0, 1);
    cyc(NOP, 1, 1, 0, 0, 1);
    check("mem_last_frz", 32'(ex_en), 32'd0);
    cyc(NOP, 1, 0, 0, 0, 1);
    check("mem_no_restall", 32'(pc_en), 32'd1);
    check("mem_cnt", 32'(stall_cnt), 32'd4);

    // Unconditional jump
    cyc(JMP, 0, 0, 0, 0, 1);
    check("jmp_sel", 32'(pc_sel), 32'd1);
    check("jmp_flush", 32'(ifid_flush), 32'd1);
    cyc(NOP, 0, 0, 0, 0, 1);
    check("jmp_after_sel", 32'(pc_sel), 32'd0);

    // Conditional jump, taken then not taken, two wait cycles each
    pulse_reset();
    for (int t = 1; t >= 0; t--) begin
      cyc(CJ, 0, 0, 0, 0, 1);
      check("cj_det_pc_en", 32'(pc_en), 32'd0);
      repeat (2) cyc(NOP, 0, 0, 0, 1, 1);
      cyc(NOP, 0, 0, 1, t[0], 1);
      check("cj_res_sel", 32'(pc_sel), t[0] ? 32'd2 : 32'd0);
      check("cj_res_pc_en", 32'(pc_en), 32'd1);
    end
    cyc(NOP, 0, 0, 0, 0, 1);
    check("cj_cnt", 32'(stall_cnt), 32'd6);

    // Reset in the middle of MEM_WAIT and BR_WAIT
    cyc(NOP, 1, 0, 0, 0, 1);
    cyc(NOP, 1, 0, 0, 0, 1);
    pulse_reset();
    cyc(JMP, 0, 0, 0, 0, 1);
    check("rst_mem_run", 32'(pc_sel), 32'd1);
    cyc(CJ, 0, 0, 0, 0, 1);
    cyc(NOP, 0, 0, 0, 0, 1);
    pulse_reset();
    cyc(JMP, 0, 0, 0, 0, 1);
    check("rst_br_run", 32'(pc_sel), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(rnd_ins(), $urandom_range(0, 99) < 30, $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) < 40, $urandom_range(0, 1) == 1, 1);
    end

    // Saturation of the stall counter
    pulse_reset();
    for (int n = 0; n < 70000; n++) cyc(NOP, 1, 0, 0, 0, 0);
    cyc(NOP, 1, 0, 0, 0, 1);
    check("sat_cnt", 32'(stall_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
